// File: rtl/gate_seq_pkg.sv
// Shared encodings and truth-table constants for the 2-input gate self-test sequencer.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Expected gate_y indexed by {a,b}
    localparam logic [3:0] TT_NOR = 4'b0001;
    localparam logic [3:0] TT_AND = 4'b1000;
    localparam logic [3:0] TT_OR  = 4'b1110;
    localparam logic [3:0] TT_XOR = 4'b0110;

    localparam int CNT_W = 4;

endpackage

// File: rtl/gate_exhaustive_sequencer.sv
// Self-test controller that walks a 2-input gate through all four input vectors and checks gate_y.
// Optional first-failure log ports are built when GATE_SEQ_ERROR_LOG_EN is defined.
module gate_exhaustive_sequencer
    import gate_seq_pkg::*;
#(
    parameter int         SETTLE_CYC  = 2,
    parameter logic [3:0] TRUTH_TABLE = TT_NOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       gate_y,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
`ifdef GATE_SEQ_ERROR_LOG_EN
    ,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_vld
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_V = CNT_W'(SETTLE_CYC);

    state_t           state, state_d;
    logic [1:0]       vec, vec_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       err_d;
    logic             pass_d, done_d, busy_d, a_d, b_d;
    logic             mism;
`ifdef GATE_SEQ_ERROR_LOG_EN
    logic [1:0]       ffv_d;
    logic             ffvld_d;
`endif

    function automatic logic [2:0] sat_inc(input logic [2:0] c);
        return (c >= 3'd4) ? 3'd4 : c + 3'd1;
    endfunction

    always_comb begin
        state_d = state;
        vec_d   = vec;
        cnt_d   = cnt;
        err_d   = err_cnt;
        pass_d  = pass;
        done_d  = 1'b0;
        busy_d  = busy;
        a_d     = gate_a;
        b_d     = gate_b;
        mism    = 1'b0;
`ifdef GATE_SEQ_ERROR_LOG_EN
        ffv_d   = first_fail_vec;
        ffvld_d = first_fail_vld;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    vec_d   = 2'd0;
                    cnt_d   = '0;
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
                    busy_d  = 1'b1;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
`ifdef GATE_SEQ_ERROR_LOG_EN
                    ffv_d   = 2'd0;
                    ffvld_d = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (cnt != SETTLE_V) begin
                    cnt_d = cnt + CNT_W'(1);
                end else begin
                    mism = (gate_y != TRUTH_TABLE[vec]);
                    if (mism) err_d = sat_inc(err_cnt);
`ifdef GATE_SEQ_ERROR_LOG_EN
                    if (mism && !first_fail_vld) begin
                        ffv_d   = vec;
                        ffvld_d = 1'b1;
                    end
`endif
                    // pass must see this edge's count, including a final-vector mismatch
                    if (vec == 2'd3) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (err_d == 3'd0);
                    end else begin
                        vec_d        = vec + 2'd1;
                        cnt_d        = '0;
                        {a_d, b_d}   = vec + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            vec     <= 2'd0;
            cnt     <= '0;
            err_cnt <= 3'd0;
            pass    <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            gate_a  <= 1'b0;
            gate_b  <= 1'b0;
`ifdef GATE_SEQ_ERROR_LOG_EN
            first_fail_vec <= 2'd0;
            first_fail_vld <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            vec     <= vec_d;
            cnt     <= cnt_d;
            err_cnt <= err_d;
            pass    <= pass_d;
            done    <= done_d;
            busy    <= busy_d;
            gate_a  <= a_d;
            gate_b  <= b_d;
`ifdef GATE_SEQ_ERROR_LOG_EN
            first_fail_vec <= ffv_d;
            first_fail_vld <= ffvld_d;
`endif
        end
    end

endmodule

// File: tb/tb_gate_exhaustive_sequencer.sv
// Directed bench: real gate primitives under test, table-driven runs plus hold/reset/zero-settle sequences.
module tb_gate_exhaustive_sequencer;
    import gate_seq_pkg::*;

    logic clk = 1'b0;
    logic rst, start0, start1;
    int   sel;
    always #5 clk = ~clk;

    // DUT0: SETTLE_CYC=2, gate selectable among NOR / OR / NOR-wrong-at-11 / AND
    logic a0, b0, y0, busy0, done0, pass0;
    logic [2:0] err0;
    logic y_nor, y_or, y_and, y_bad;
    nor g_nor (y_nor, a0, b0);
    or  g_or  (y_or,  a0, b0);
    and g_and (y_and, a0, b0);
    or  g_bad (y_bad, y_nor, y_and);
    assign y0 = (sel == 0) ? y_nor : (sel == 1) ? y_or : (sel == 2) ? y_bad : y_and;

    // DUT1: SETTLE_CYC=0 with a NOR gate
    logic a1, b1, y1, busy1, done1, pass1;
    logic [2:0] err1;
    nor g_nor1 (y1, a1, b1);

`ifdef GATE_SEQ_ERROR_LOG_EN
    logic [1:0] ffv0, ffv1;
    logic       ffvld0, ffvld1;
`endif

    gate_exhaustive_sequencer #(.SETTLE_CYC(2), .TRUTH_TABLE(TT_NOR)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .gate_y(y0),
        .gate_a(a0), .gate_b(b0), .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0)
`ifdef GATE_SEQ_ERROR_LOG_EN
        , .first_fail_vec(ffv0), .first_fail_vld(ffvld0)
`endif
    );

    gate_exhaustive_sequencer #(.SETTLE_CYC(0), .TRUTH_TABLE(TT_NOR)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .gate_y(y1),
        .gate_a(a1), .gate_b(b1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1)
`ifdef GATE_SEQ_ERROR_LOG_EN
        , .first_fail_vec(ffv1), .first_fail_vld(ffvld1)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int sel;
        int err;
        int pass;
        int ffv;
        int vld;
    } vec_t;
    vec_t tbl[4];

    // Called just after a negedge; returns just after the negedge following DONE exit.
    task automatic run_s2(input string tag, input vec_t v);
        sel    = v.sel;
        start0 = 1'b1;
        @(negedge clk);                 // edge k accepted
        start0 = 1'b0;
        chk({tag, " busy@k"}, busy0, 1);
        chk({tag, " pass_clr@k"}, pass0, 0);
        chk({tag, " err_clr@k"}, err0, 0);
        chk({tag, " vec@k"}, {a0, b0}, 0);
        for (int j = 1; j < 12; j++) begin
            @(negedge clk);
            chk($sformatf("%s vec@k+%0d", tag, j), {a0, b0}, j / 3);
            chk($sformatf("%s nodone@k+%0d", tag, j), done0, 0);
        end
        @(negedge clk);                 // after edge k+12
        chk({tag, " done"}, done0, 1);
        chk({tag, " err"}, err0, v.err);
        chk({tag, " pass"}, pass0, v.pass);
`ifdef GATE_SEQ_ERROR_LOG_EN
        chk({tag, " ffv"}, ffv0, v.ffv);
        chk({tag, " ffvld"}, ffvld0, v.vld);
`endif
        @(negedge clk);
        chk({tag, " done_drop"}, done0, 0);
        chk({tag, " busy_drop"}, busy0, 0);
        chk({tag, " gates_idle"}, {a0, b0}, 0);
        chk({tag, " err_hold"}, err0, v.err);
        chk({tag, " pass_hold"}, pass0, v.pass);
    endtask

    initial begin
        int ndone;
        tbl[0] = '{sel: 0, err: 0, pass: 1, ffv: 0, vld: 0};  // NOR
        tbl[1] = '{sel: 1, err: 4, pass: 0, ffv: 0, vld: 1};  // OR
        tbl[2] = '{sel: 2, err: 1, pass: 0, ffv: 3, vld: 1};  // wrong only at 11
        tbl[3] = '{sel: 3, err: 2, pass: 0, ffv: 0, vld: 1};  // AND

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        chk("rst busy", busy0, 0);
        chk("rst done", done0, 0);
        chk("rst pass", pass0, 0);
        chk("rst err", err0, 0);
        chk("rst gates", {a0, b0}, 0);
        chk("rst busy1", busy1, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 4; i++) run_s2($sformatf("tbl%0d", i), tbl[i]);

        // start held high: one run, rejected on DONE->IDLE edge, accepted on first IDLE cycle
        sel = 0; start0 = 1'b1; ndone = 0;
        for (int j = 0; j <= 13; j++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("hold done_count", ndone, 1);
        chk("hold busy@k+13", busy0, 0);
        @(negedge clk);
        chk("hold reaccept", busy0, 1);
        start0 = 1'b0; ndone = 0;
        for (int j = 1; j <= 13; j++) begin
            @(negedge clk);
            if (done0) ndone++;
        end
        chk("hold run2 done_count", ndone, 1);
        chk("hold run2 pass", pass0, 1);
        chk("hold run2 busy", busy0, 0);

        // reset while vector 2 is being driven
        sel = 1; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (7) @(negedge clk);       // after edge k+7
        chk("abort vec2", {a0, b0}, 2);
        chk("abort err_before", err0, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", busy0, 0);
        chk("abort done", done0, 0);
        chk("abort gates", {a0, b0}, 0);
        chk("abort err", err0, 0);
        chk("abort pass", pass0, 0);
`ifdef GATE_SEQ_ERROR_LOG_EN
        chk("abort ffvld", ffvld0, 0);
`endif
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0 || busy0) ndone++;
        end
        chk("abort stays_idle", ndone, 0);
        run_s2("post_abort", tbl[0]);

        // SETTLE_CYC=0: one cycle per vector
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j > 0) @(negedge clk);
            chk($sformatf("s0 vec@k+%0d", j), {a1, b1}, j);
            chk($sformatf("s0 busy@k+%0d", j), busy1, 1);
            chk($sformatf("s0 nodone@k+%0d", j), done1, 0);
        end
        @(negedge clk);
        chk("s0 done", done1, 1);
        chk("s0 pass", pass1, 1);
        chk("s0 err", err1, 0);
        @(negedge clk);
        chk("s0 done_drop", done1, 0);
        chk("s0 busy_drop", busy1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
